reduce_accum_bram: RTL and testbench
====================================

// Module: reduce_accum_bram
// PURPOSE
//  Key-indexed accumulator RAM for the reduce stage: each accepted update adds (or maxes) a value into the entry
//  selected by its key, with read-modify-write hazard forwarding so back-to-back updates to one key are exact.
//  Independent host read port drains results; a clear sweep zeroes all entries after reset or on request.
//  Sits between the shuffle/key-route logic and the result-drain logic of each reducer.
// PARAMETERS
//  C_WIDTH      32  accumulator entry width (bits)
//  C_DIN_WIDTH  16  update data width, must be <= C_WIDTH; zero-extended before combining
//  C_LOG_DEPTH  4   log2 of entry count; C_DEPTH = 1<<C_LOG_DEPTH
//  C_MODE       0   0 = add, 1 = unsigned max
//  C_SAT        1   add mode only: 1 = saturate at all-ones, 0 = wrap modulo 2^C_WIDTH
// PORTS
//  i_clk        in   1            clock; all logic on posedge
//  i_rst        in   1            synchronous, active-high reset
//  i_upd_valid  in   1            update request
//  i_upd_key    in   C_LOG_DEPTH  entry index to update
//  i_upd_data   in   C_DIN_WIDTH  value to combine into entry
//  o_upd_ready  out  1            update accepted when i_upd_valid & o_upd_ready
//  i_clr        in   1            single-cycle pulse: start clear sweep
//  o_busy       out  1            clear sweep in progress
//  i_ce         in   1            host read enable
//  i_raddr      in   C_LOG_DEPTH  host read index
//  o_rdata      out  C_WIDTH      host read data, registered
//  o_rvalid     out  1            o_rdata valid this cycle
//  o_sat        out  1            sticky: an add saturated (C_SAT=1) or wrapped (C_SAT=0)
//  o_err        out  1            sticky: update presented while o_upd_ready=0 (dropped)
// BEHAVIOUR
//  Reset: o_rdata=0, o_rvalid=0, o_sat=0, o_err=0, pipeline valids=0; sweep counter=0, o_busy=1 on the first
//   cycle after i_rst deasserts. Reset mid-sweep or mid-update aborts it and restarts the sweep from entry 0.
//  FSM: CLEAR -> IDLE when sweep counter writes entry C_DEPTH-1; IDLE -> CLEAR on i_clr. i_clr in CLEAR ignored.
//  CLEAR: writes 0 to entry cnt each cycle, cnt 0..C_DEPTH-1 (exactly C_DEPTH cycles); o_busy=1, o_upd_ready=0.
//  o_upd_ready = (state==IDLE) & ~i_clr. Host reads are legal in CLEAR and return current RAM contents.
//  Clear entered with an update in S1: that update still writes at the next edge, then the sweep overwrites it.
//  Update pipeline: edge E0 accept, key/data registered into S1, RAM read of key launched.
//   Cycle after E0: old = (wb_vld & wb_key==s1_key) ? wb_val : ram_q; new = f(old, data); written at edge E1,
//   and registered as wb_key/wb_val/wb_vld for forwarding. Throughput 1 update/cycle, any key sequence.
//  f: add -> old+data in C_WIDTH+1 bits; carry set => o_sat<=1 and result = all-ones (C_SAT=1) or low bits.
//     max -> (data > old) ? data : old; o_sat unaffected.
//  Host read: i_ce sampled at edge; o_rdata/o_rvalid updated at that edge (1-cycle latency); i_ce=0 holds o_rdata,
//   o_rvalid=0. Read at the same edge as a write to that index returns the pre-write value; an update accepted at
//   E0 is visible to a read sampled at E2 or later.
//  o_err set when i_upd_valid=1 & o_upd_ready=0; cleared only by i_rst.
// STRUCTURE
//  Shared package reduce_pkg: mode constants REDUCE_MODE_ADD=0, REDUCE_MODE_MAX=1, FSM state encoding.
//  Sub-module reduce_sdp_ram (1 write port, 1 registered read port, parametric width/depth), instantiated twice
//   with identical write port: copy A serves the RMW read, copy B serves host reads. Write mux: sweep vs. update.
// TESTING
//  Reset, then hold i_rst low 16 cycles (depth 16) -> o_busy=1 exactly 16 cycles, then all 16 entries read 0.
//  Updates key 3 data 5,7,9 on consecutive cycles -> host read of key 3 at E2 of last update returns 21.
//  Interleaved keys 1,2,1,2 data 1 each, back-to-back -> key1=2, key2=2; no forwarding corruption.
//  C_SAT=1: entry at 0xFFFF_FFF0 plus 0x20 -> 0xFFFF_FFFF, o_sat=1; C_SAT=0 -> 0x0000_0010, o_sat=1.
//  C_MODE=1: updates 4, 9, 2 to key 0 -> reads 9; i_clr pulse -> o_upd_ready=0 16 cycles, key 0 then reads 0.
//  Update driven during sweep -> dropped, o_err=1 sticky until i_rst; i_rst mid-sweep -> sweep restarts at 0.

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared constants for the reduce-stage accumulator.
// Combine modes and clear-sweep FSM encoding.
package reduce_pkg;

  localparam int REDUCE_MODE_ADD = 0;
  localparam int REDUCE_MODE_MAX = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } reduce_state_t;

endpackage

// File: rtl/reduce_sdp_ram.sv
// Simple dual-port RAM: one write port,
// one registered read port with enable.
module reduce_sdp_ram #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [C_LOG_DEPTH-1:0] i_waddr,
  input  logic [C_WIDTH-1:0]     i_wdata,
  input  logic                   i_re,
  input  logic [C_LOG_DEPTH-1:0] i_raddr,
  output logic [C_WIDTH-1:0]     o_rdata
);

  localparam int C_DEPTH = 1 << C_LOG_DEPTH;

  logic [C_WIDTH-1:0] mem [C_DEPTH];

  // write port; no reset, contents zeroed by the sweep
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // read port returns pre-write data on a same-edge collision
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/reduce_accum_bram.sv
// Key-indexed accumulator RAM with RMW forwarding,
// host read port and a post-reset / on-demand clear sweep.
module reduce_accum_bram
  import reduce_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_DIN_WIDTH = 16,
  parameter int C_LOG_DEPTH = 4,
  parameter int C_MODE      = 0,
  parameter int C_SAT       = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_upd_valid,
  input  logic [C_LOG_DEPTH-1:0] i_upd_key,
  input  logic [C_DIN_WIDTH-1:0] i_upd_data,
  output logic                   o_upd_ready,
  input  logic                   i_clr,
  output logic                   o_busy,
  input  logic                   i_ce,
  input  logic [C_LOG_DEPTH-1:0] i_raddr,
  output logic [C_WIDTH-1:0]     o_rdata,
  output logic                   o_rvalid,
  output logic                   o_sat,
  output logic                   o_err
);

  localparam int C_DEPTH = 1 << C_LOG_DEPTH;
  localparam logic [C_LOG_DEPTH-1:0] C_LAST =
    C_LOG_DEPTH'(C_DEPTH - 1);

  reduce_state_t state;
  reduce_state_t state_nx;

  logic [C_LOG_DEPTH-1:0] cnt;
  logic                   sweep_we;

  logic                   accept;
  logic                   s1_vld;
  logic [C_LOG_DEPTH-1:0] s1_key;
  logic [C_DIN_WIDTH-1:0] s1_data;

  logic                   wb_vld;
  logic [C_LOG_DEPTH-1:0] wb_key;
  logic [C_WIDTH-1:0]     wb_val;

  logic [C_WIDTH-1:0]     ram_q;
  logic [C_WIDTH-1:0]     old_val;
  logic [C_WIDTH-1:0]     din_ext;
  logic [C_WIDTH:0]       sum;
  logic                   carry;
  logic [C_WIDTH-1:0]     new_val;

  logic                   ram_we;
  logic [C_LOG_DEPTH-1:0] ram_waddr;
  logic [C_WIDTH-1:0]     ram_wdata;

  assign o_busy      = (state == ST_CLEAR);
  assign o_upd_ready = (state == ST_IDLE) & ~i_clr;
  assign accept      = i_upd_valid & o_upd_ready;

  // state register; reset restarts the sweep
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_CLEAR;
    else       state <= state_nx;
  end

  // next state and sweep write strobe
  always_comb begin
    state_nx = state;
    sweep_we = 1'b0;
    unique case (1'b1)
      (state == ST_CLEAR): begin
        sweep_we = 1'b1;
        if (cnt == C_LAST) state_nx = ST_IDLE;
      end
      (state == ST_IDLE): begin
        if (i_clr) state_nx = ST_CLEAR;
      end
      default: ;
    endcase
  end

  // sweep index; wraps to 0 ready for the next sweep
  always_ff @(posedge i_clk) begin
    if (i_rst)         cnt <= '0;
    else if (sweep_we) cnt <= cnt + 1'b1;
  end

  // S1 capture and write-back forwarding registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld <= 1'b0;
      wb_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      wb_vld <= s1_vld;
    end
    if (accept) begin
      s1_key  <= i_upd_key;
      s1_data <= i_upd_data;
    end
    wb_key <= s1_key;
    wb_val <= new_val;
  end

  // combine: forward last write when RAM read is stale
  always_comb begin
    old_val = ram_q;
    if (wb_vld && (wb_key == s1_key)) old_val = wb_val;
    din_ext = C_WIDTH'(s1_data);
    sum     = {1'b0, old_val} + {1'b0, din_ext};
    carry   = sum[C_WIDTH];
    new_val = sum[C_WIDTH-1:0];
    if (C_MODE == REDUCE_MODE_MAX) begin
      carry   = 1'b0;
      new_val = (din_ext > old_val) ? din_ext : old_val;
    end else if (carry && (C_SAT != 0)) begin
      new_val = '1;
    end
  end

  // write mux: a pending update wins over the sweep
  always_comb begin
    ram_we    = s1_vld | sweep_we;
    ram_waddr = cnt;
    ram_wdata = '0;
    if (s1_vld) begin
      ram_waddr = s1_key;
      ram_wdata = new_val;
    end
  end

  // sticky overflow and dropped-update flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sat <= 1'b0;
      o_err <= 1'b0;
    end else begin
      if (s1_vld && carry)              o_sat <= 1'b1;
      if (i_upd_valid && !o_upd_ready) o_err <= 1'b1;
    end
  end

  // host read valid follows the sampled enable
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rvalid <= 1'b0;
    else       o_rvalid <= i_ce;
  end

  reduce_sdp_ram #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_DEPTH (C_LOG_DEPTH)
  ) u_ram_rmw (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (ram_wdata),
    .i_re    (1'b1),
    .i_raddr (i_upd_key),
    .o_rdata (ram_q)
  );

  reduce_sdp_ram #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_DEPTH (C_LOG_DEPTH)
  ) u_ram_host (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (ram_wdata),
    .i_re    (i_ce),
    .i_raddr (i_raddr),
    .o_rdata (o_rdata)
  );

endmodule

// File: tb/tb_reduce_accum_bram.sv
// Directed bench for reduce_accum_bram:
// add/saturate/wrap/max instances driven in parallel.
module tb_reduce_accum_bram;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [3:0]  upd_key;
  logic [15:0] d16;
  logic [31:0] d32;
  logic        clr;
  logic        ce;
  logic [3:0]  raddr;

  logic        rdy0, busy0, rvalid0, sat0, err0;
  logic [31:0] rdata0;
  logic        rdy_s, busy_s, rvalid_s, sat_s, err_s;
  logic [31:0] rdata_s;
  logic        rdy_w, busy_w, rvalid_w, sat_w, err_w;
  logic [31:0] rdata_w;
  logic        rdy_m, busy_m, rvalid_m, sat_m, err_m;
  logic [31:0] rdata_m;

  int n_vec = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  reduce_accum_bram dut (
    .i_clk(clk), .i_rst(rst),
    .i_upd_valid(upd_valid), .i_upd_key(upd_key),
    .i_upd_data(d16), .o_upd_ready(rdy0),
    .i_clr(clr), .o_busy(busy0),
    .i_ce(ce), .i_raddr(raddr),
    .o_rdata(rdata0), .o_rvalid(rvalid0),
    .o_sat(sat0), .o_err(err0)
  );

  reduce_accum_bram #(.C_DIN_WIDTH(32), .C_SAT(1)) dut_s (
    .i_clk(clk), .i_rst(rst),
    .i_upd_valid(upd_valid), .i_upd_key(upd_key),
    .i_upd_data(d32), .o_upd_ready(rdy_s),
    .i_clr(clr), .o_busy(busy_s),
    .i_ce(ce), .i_raddr(raddr),
    .o_rdata(rdata_s), .o_rvalid(rvalid_s),
    .o_sat(sat_s), .o_err(err_s)
  );

  reduce_accum_bram #(.C_DIN_WIDTH(32), .C_SAT(0)) dut_w (
    .i_clk(clk), .i_rst(rst),
    .i_upd_valid(upd_valid), .i_upd_key(upd_key),
    .i_upd_data(d32), .o_upd_ready(rdy_w),
    .i_clr(clr), .o_busy(busy_w),
    .i_ce(ce), .i_raddr(raddr),
    .o_rdata(rdata_w), .o_rvalid(rvalid_w),
    .o_sat(sat_w), .o_err(err_w)
  );

  reduce_accum_bram #(.C_MODE(1)) dut_m (
    .i_clk(clk), .i_rst(rst),
    .i_upd_valid(upd_valid), .i_upd_key(upd_key),
    .i_upd_data(d16), .o_upd_ready(rdy_m),
    .i_clr(clr), .o_busy(busy_m),
    .i_ce(ce), .i_raddr(raddr),
    .o_rdata(rdata_m), .o_rvalid(rvalid_m),
    .o_sat(sat_m), .o_err(err_m)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic upd(
    input logic [3:0]  k,
    input logic [31:0] d
  );
    upd_valid = 1'b1;
    upd_key   = k;
    d32       = d;
    d16       = d[15:0];
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    ce    = 1'b1;
    raddr = a;
    cyc();
    ce    = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy0 && cnt < 40) begin
      cnt++;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_key = '0;
    d16 = '0; d32 = '0; clr = 1'b0;
    ce = 1'b0; raddr = '0;
    repeat (3) cyc();
    chk("rst_rdata",  rdata0,  32'd0);
    chk("rst_rvalid", 32'(rvalid0), 32'd0);
    chk("rst_sat",    32'(sat0),    32'd0);
    chk("rst_err",    32'(err0),    32'd0);
    chk("rst_busy",   32'(busy0),   32'd1);
    chk("rst_ready",  32'(rdy0),    32'd0);
    rst = 1'b0;
    count_busy(n);
    chk("init_sweep_len", 32'(n), 32'd16);
    chk("init_ready", 32'(rdy0), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("init_zero", rdata0, 32'd0);
    end
    chk("init_rvalid", 32'(rvalid0), 32'd1);

    upd(4'd3, 32'd5);
    upd(4'd3, 32'd7);
    upd(4'd3, 32'd9);
    rd(4'd3);
    chk("k3_e1_prewrite", rdata0, 32'd12);
    rd(4'd3);
    chk("k3_sum", rdata0, 32'd21);

    upd(4'd1, 32'd1);
    upd(4'd2, 32'd1);
    upd(4'd1, 32'd1);
    upd(4'd2, 32'd1);
    cyc();
    rd(4'd1);
    chk("k1_inter", rdata0, 32'd2);
    rd(4'd2);
    chk("k2_inter", rdata0, 32'd2);
    cyc();
    chk("hold_rvalid", 32'(rvalid0), 32'd0);
    chk("hold_rdata",  rdata0, 32'd2);

    chk("sat_pre", 32'(sat_s), 32'd0);
    upd(4'd5, 32'hFFFF_FFF0);
    upd(4'd5, 32'h0000_0020);
    cyc();
    rd(4'd5);
    chk("sat_val",  rdata_s, 32'hFFFF_FFFF);
    chk("sat_flag", 32'(sat_s), 32'd1);
    chk("wrap_val", rdata_w, 32'h0000_0010);
    chk("wrap_flag", 32'(sat_w), 32'd1);
    chk("add16_val", rdata0, 32'h0001_0010);
    chk("add16_nosat", 32'(sat0), 32'd0);

    upd(4'd0, 32'd4);
    upd(4'd0, 32'd9);
    upd(4'd0, 32'd2);
    cyc();
    rd(4'd0);
    chk("max_val", rdata_m, 32'd9);
    chk("max_nosat", 32'(sat_m), 32'd0);
    chk("add_k0", rdata0, 32'd15);

    chk("err_pre", 32'(err_m), 32'd0);
    clr = 1'b1;
    #1;
    chk("clr_ready", 32'(rdy_m), 32'd0);
    cyc();
    clr = 1'b0;
    n = 0;
    while (!rdy_m && n < 40) begin
      upd_valid = (n == 3);
      upd_key   = 4'd0;
      d16       = 16'd7;
      d32       = 32'd7;
      n++;
      cyc();
    end
    upd_valid = 1'b0;
    chk("clr_len", 32'(n), 32'd16);
    chk("err_sticky_m", 32'(err_m), 32'd1);
    chk("err_sticky_0", 32'(err0), 32'd1);
    rd(4'd0);
    chk("clr_k0_max", rdata_m, 32'd0);
    chk("clr_k0_add", rdata0, 32'd0);
    rd(4'd3);
    chk("clr_k3", rdata0, 32'd0);
    repeat (3) cyc();
    chk("err_still", 32'(err0), 32'd1);

    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_err_clr", 32'(err0), 32'd0);
    chk("rst_sat_clr", 32'(sat_s), 32'd0);
    count_busy(n);
    chk("rst_sweep_len", 32'(n), 32'd16);
    upd(4'd7, 32'd3);
    cyc();
    rd(4'd7);
    chk("post_rst_upd", rdata0, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
